// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter producing start bit, DATA_BITS data
// bits (LSB first) and a stop bit, each held CLKS_PER_BIT clocks.
// Latency: tx drops to the start level on the edge that accepts start; a frame
// lasts (DATA_BITS+2)*CLKS_PER_BIT cycles and done pulses on the first idle cycle.
// Backpressure: start is ignored while busy (not queued); the caller holds or
// re-issues it. start is accepted again in the done cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, abandons any frame in progress
//   data_in  in   word to send, sampled only on the accepting edge
//   start    in   send request, honoured only in IDLE
//   tx       out  serial line, idles high
//   busy     out  high during START/DATA/STOP
//   done     out  one-cycle pulse after the stop bit
module serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 start,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [BW-1:0]         r_idx;
   logic [BW-1:0]         w_idx_nxt;
   logic [DATA_BITS-1:0]  r_shift;
   logic [DATA_BITS-1:0]  w_shift_nxt;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;
   logic                  w_done_nxt;
   logic                  w_bit_end;

   assign w_bit_end = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = START;
               w_shift_nxt = data_in;
               w_cnt_nxt   = '0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt = DATA;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt   = r_idx + BW'(1);
                  w_shift_nxt = r_shift >> 1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs are derived from the next state so they can be registered
      // without lagging the state by a cycle.
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
      w_done_nxt = (r_state == STOP) && (w_state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (C=4/N=8 and C=1/N=1) share clock and
// reset. A frame-position model predicts tx/busy/done every cycle; directed
// scenarios add literal expectations on recorded traces.
module tb_serial_tx;

   logic       clk;
   logic       rst;
   logic       start_a, start_b;
   logic [7:0] data_a;
   logic [0:0] data_b;
   logic       tx_a, busy_a, done_a;
   logic       tx_b, busy_b, done_b;

   int n_chk  = 0;
   int n_fail = 0;

   serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_a (
      .clk(clk), .rst(rst), .data_in(data_a), .start(start_a),
      .tx(tx_a), .busy(busy_a), .done(done_a));

   serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(1)) u_b (
      .clk(clk), .rst(rst), .data_in(data_b), .start(start_b),
      .tx(tx_b), .busy(busy_b), .done(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mpos = cycles elapsed since the accepting edge, -1 when idle.
   int          mc[2] = '{4, 1};
   int          mn[2] = '{8, 1};
   int          mpos[2] = '{-1, -1};
   logic [15:0] mdat[2];
   logic        mdone[2];
   bit          mvalid = 1'b0;
   logic        m_st[2];
   logic [15:0] m_di[2];

   always @(posedge clk) begin
      m_st[0] = start_a;      m_st[1] = start_b;
      m_di[0] = 16'(data_a);  m_di[1] = 16'(data_b);
      for (int k = 0; k < 2; k++) begin
         mdone[k] = 1'b0;
         if (rst) begin
            mpos[k] = -1;
         end else if (mpos[k] < 0) begin
            if (m_st[k]) begin
               mpos[k] = 0;
               mdat[k] = m_di[k];
            end
         end else begin
            mpos[k] = mpos[k] + 1;
            if (mpos[k] == (mn[k] + 2) * mc[k]) begin
               mpos[k]  = -1;
               mdone[k] = 1'b1;
            end
         end
      end
      if (rst) mvalid = 1'b1;
   end

   function automatic logic exp_tx(input int k);
      int b;
      if (mpos[k] < 0) return 1'b1;
      b = mpos[k] / mc[k];
      if (b == 0) return 1'b0;
      if (b <= mn[k]) return mdat[k][b-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (mvalid) begin
         chk("model_tx_a",   32'(tx_a),   32'(exp_tx(0)));
         chk("model_busy_a", 32'(busy_a), 32'(mpos[0] >= 0));
         chk("model_done_a", 32'(done_a), 32'(mdone[0]));
         chk("model_tx_b",   32'(tx_b),   32'(exp_tx(1)));
         chk("model_busy_b", 32'(busy_b), 32'(mpos[1] >= 0));
         chk("model_done_b", 32'(done_b), 32'(mdone[1]));
      end
   end

   // ---------------- directed traces ----------------
   logic tr_tx[0:127];
   logic tr_busy[0:127];
   logic tr_done[0:127];

   // Called just after a negedge. Cycle k=0 is the cycle after accepting edge E.
   // sk: negedge at which a second start is raised (accepted at edge E+sk+1).
   // rk: negedge at which rst is raised (sampled at edge E+rk+1).
   task automatic run_a(input logic [7:0] d, input int sk, input logic [7:0] d2,
                        input int rk, input int ncyc);
      start_a = 1'b1;
      data_a  = d;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         tr_tx[k]   = tx_a;
         tr_busy[k] = busy_a;
         tr_done[k] = done_a;
         if (k == 0) begin
            start_a = 1'b0;
            data_a  = 8'($urandom);
         end
         if (k == sk) begin
            start_a = 1'b1;
            data_a  = d2;
         end else if (k == sk + 1) begin
            start_a = 1'b0;
            data_a  = 8'($urandom);
         end
         if (k == rk) rst = 1'b1;
         else if (k == rk + 1) rst = 1'b0;
      end
      start_a = 1'b0;
      rst     = 1'b0;
   endtask

   function automatic logic [7:0] dec(input int off);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = tr_tx[off + (b + 1) * 4 + 2];
      return r;
   endfunction

   function automatic int cnt_busy(input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++) if (tr_busy[k]) n++;
      return n;
   endfunction

   function automatic int cnt_done(input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++) if (tr_done[k]) n++;
      return n;
   endfunction

   initial begin
      logic [9:0] fr;
      int         mism;

      // Reset held for 3 edges with start high and all-ones data.
      rst = 1'b1; start_a = 1'b1; data_a = 8'hFF; start_b = 1'b1; data_b = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx",   32'(tx_a),   32'd1);
         chk("rst_busy", 32'(busy_a), 32'd0);
         chk("rst_done", 32'(done_a), 32'd0);
      end
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      @(negedge clk);
      chk("rst_nostart_busy", 32'(busy_a), 32'd0);
      chk("rst_nostart_tx",   32'(tx_a),   32'd1);
      repeat (2) @(negedge clk);

      // Single frame 0xA5.
      run_a(8'hA5, -10, 8'h00, -10, 50);
      fr   = {1'b1, 8'hA5, 1'b0};
      mism = 0;
      for (int k = 0; k < 40; k++) if (tr_tx[k] !== fr[k/4]) mism++;
      chk("a5_sequence",  32'(mism), 32'd0);
      chk("a5_decode",    32'(dec(0)), 32'hA5);
      chk("a5_busy_len",  32'(cnt_busy(0, 49)), 32'd40);
      chk("a5_done_cnt",  32'(cnt_done(0, 49)), 32'd1);
      chk("a5_done_at40", 32'(tr_done[40]), 32'd1);
      chk("a5_tx_idle40", 32'(tr_tx[40]), 32'd1);

      // Start while busy is ignored.
      run_a(8'h3C, 9, 8'hFF, -10, 50);
      chk("ign_decode",   32'(dec(0)), 32'h3C);
      chk("ign_done_cnt", 32'(cnt_done(0, 49)), 32'd1);
      chk("ign_busy_len", 32'(cnt_busy(0, 49)), 32'd40);

      // Back-to-back: second start raised in the done cycle.
      run_a(8'h01, 40, 8'h80, -10, 90);
      chk("b2b_decode1",  32'(dec(0)), 32'h01);
      chk("b2b_done1",    32'(tr_done[40]), 32'd1);
      chk("b2b_start2",   32'(tr_tx[41]), 32'd0);
      chk("b2b_busy2",    32'(tr_busy[41]), 32'd1);
      chk("b2b_decode2",  32'(dec(41)), 32'h80);
      chk("b2b_done2",    32'(tr_done[81]), 32'd1);
      chk("b2b_done_cnt", 32'(cnt_done(0, 89)), 32'd2);

      // Reset at E+20 mid-data, new start accepted at E+25.
      run_a(8'hC3, 24, 8'h5A, 19, 75);
      chk("rmid_tx",       32'(tr_tx[20]), 32'd1);
      chk("rmid_busy",     32'(tr_busy[20]), 32'd0);
      chk("rmid_nodone",   32'(cnt_done(0, 64)), 32'd0);
      chk("rmid_restart",  32'(tr_tx[25]), 32'd0);
      chk("rmid_decode",   32'(dec(25)), 32'h5A);
      chk("rmid_done65",   32'(tr_done[65]), 32'd1);

      // Corner parameters C=1, N=1, data 0.
      start_b = 1'b1; data_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tr_tx[k] = tx_b; tr_busy[k] = busy_b; tr_done[k] = done_b;
         start_b = 1'b0; data_b = 1'b1;
      end
      chk("c1_seq", {29'd0, tr_tx[0], tr_tx[1], tr_tx[2]}, 32'b001);
      chk("c1_busy", 32'(cnt_busy(0, 4)), 32'd3);
      chk("c1_done3", 32'(tr_done[3]), 32'd1);
      chk("c1_done_cnt", 32'(cnt_done(0, 4)), 32'd1);

      // Randomized traffic on both instances, checked by the model.
      for (int i = 0; i < 3000; i++) begin
         start_a = ($urandom_range(0, 5) == 0);
         data_a  = 8'($urandom);
         start_b = ($urandom_range(0, 3) == 0);
         data_b  = 1'($urandom);
         rst     = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (50) @(negedge clk);
      chk("final_idle_a", 32'(busy_a), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
